nibble_serial_add_ctrl: RTL and testbench
=========================================

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 clk_in  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_in  input  1  reset, synchronous, active-high.
REQ-004 start_in  input  1  request a new addition; sampled only in IDLE.
REQ-005 A_in  input  W  operand A; captured on the accepted start.
REQ-006 B_in  input  W  operand B; captured on the accepted start.
REQ-007 C_in  input  1  carry-in; captured on the accepted start.
REQ-008 busy_out  output  1  high while an operation is in progress.
REQ-009 done_out  output  1  one-cycle pulse when the result becomes valid.
REQ-010 S_out  output  W  sum; holds its value until the next accepted start.
REQ-011 C_out  output  1  final carry-out; holds like S_out.
REQ-012 ovf_out  output  1  signed overflow of the W-bit result; holds like S_out.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 IDLE: if start_in=1 at an edge, capture A_in, B_in and C_in, clear the nibble index to 0 and go to RUN; otherwise stay in IDLE.
REQ-015 RUN: each cycle, one shared 4-bit adder slice SHALL add nibble[idx] of A and B plus the carry register.
REQ-016 At each RUN edge: write the slice sum into S_out nibble idx, load the slice carry into the carry register, and increment idx.
REQ-017 Nibbles SHALL be processed LSB first; the carry register SHALL start from the captured C_in.
REQ-018 After the edge that writes nibble NIBBLES-1: go to DONE, drive C_out from the final carry, and compute ovf_out = carry into MSB XOR carry out of MSB.
REQ-019 DONE SHALL last exactly one cycle with done_out=1, then return to IDLE.
REQ-020 Latency: start accepted at edge k; done_out SHALL be high in the cycle after edge k+NIBBLES; busy_out SHALL be high in RUN only.
REQ-021 start_in in RUN or DONE SHALL be ignored; it is not queued.
REQ-022 A_in, B_in and C_in changes after capture SHALL NOT affect the result.
REQ-023 S_out may show a partial result while busy_out=1; it is valid only from done_out onward.
REQ-024 The nibble index SHALL be ceil(log2(NIBBLES)) bits wide, minimum 1, and SHALL never wrap inside an operation.

Reset
REQ-025 rst_in=1 at an edge SHALL force IDLE and clear S_out, C_out, ovf_out, busy_out, done_out, idx and the carry register to 0.
REQ-026 Reset SHALL take priority over start_in and abort any RUN in progress with no done_out pulse.

Configuration
REQ-027 Macro SUB_MODE_EN:
- Defined: add input port sub_in (1 bit), captured on the accepted start.
- sub_in=1: B SHALL be inverted and the carry register SHALL start at 1, ignoring C_in, so the result is A-B.
- sub_in=0: the block behaves as an adder.
- Undefined: no sub_in port; the block only adds.

Structure
REQ-028 Package nibble_add_pkg SHALL hold the FSM state enum (IDLE/RUN/DONE) and the constant NIBBLE_W=4.
REQ-029 The slice SHALL be an instance of the team's existing fulladd4bit (A_in, B_in, C_in, C_out, S_out); no other sub-module.

Verification
REQ-030 NIBBLES=4, A=0x1234, B=0x4321, C_in=0 -> done_out on cycle 5 after start; S=0x5555, C_out=0, ovf=0.
REQ-031 A=0xFFFF, B=0x0001, C_in=0 -> S=0x0000, C_out=1, ovf=0; then A=0x7FFF, B=0x0001 -> S=0x8000, ovf=1.
REQ-032 A=0x0007, B=0x0003, C_in=1 -> S=0x000B; start_in held high through RUN -> exactly one done_out, and a second operation starts only from IDLE.
REQ-033 rst_in asserted on the second RUN cycle -> next cycle busy_out=0, S_out=0, no done_out; a following start of 0x0004+0x0003 -> S=0x0007.
REQ-034 SUB_MODE_EN defined, sub_in=1, A=0x0005, B=0x0007 -> S=0xFFFE, C_out=0; with A=0x0007, B=0x0005 -> S=0x0002, C_out=1.

Source files
------------

// File: rtl/nibble_add_pkg.sv
// Shared types for the nibble-serial adder: FSM states and slice width.
package nibble_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index width for a given slice count, never narrower than one bit.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/fulladd4bit.sv
// Purpose: 4-bit ripple adder slice with carry in/out.
// Latency: combinational. Backpressure: none.
// Flow: pure function of its inputs, no handshake.
module fulladd4bit (
    input  logic [3:0] A_in,
    input  logic [3:0] B_in,
    input  logic       C_in,
    output logic       C_out,
    output logic [3:0] S_out
);

    assign {C_out, S_out} = {1'b0, A_in} + {1'b0, B_in} + {4'b0000, C_in};

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Purpose: W-bit add (or A-B when built with SUB_MODE_EN) through one shared 4-bit slice, LSB nibble first.
// Latency: start accepted at edge k, done_out pulses in the cycle after edge k+NIBBLES.
// Backpressure: none; start_in is only sampled in IDLE and is dropped (not queued) while busy.
module nibble_serial_add_ctrl
    import nibble_add_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         start_in,
`ifdef SUB_MODE_EN
    input  logic                         sub_in,
`endif
    input  logic [NIBBLE_W*NIBBLES-1:0]  A_in,
    input  logic [NIBBLE_W*NIBBLES-1:0]  B_in,
    input  logic                         C_in,
    output logic                         busy_out,
    output logic                         done_out,
    output logic [NIBBLE_W*NIBBLES-1:0]  S_out,
    output logic                         C_out,
    output logic                         ovf_out
);

    localparam int IDX_W = idx_width(NIBBLES);

    state_t state, state_nxt;

    logic [NIBBLES-1:0][NIBBLE_W-1:0] a_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] b_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] s_q;
    logic [IDX_W-1:0]                 idx;
    logic                             carry;
    logic                             c_q;
    logic                             ovf_q;

    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_c;
    logic                last;
    logic                msb_cin;

    fulladd4bit u_slice (
        .A_in  (a_q[idx]),
        .B_in  (b_q[idx]),
        .C_in  (carry),
        .C_out (slice_c),
        .S_out (slice_s)
    );

    assign last = (idx == IDX_W'(NIBBLES - 1));
    // Carry into the top bit recovered from the sum bit: s3 = a3 ^ b3 ^ cin3.
    assign msb_cin = a_q[idx][NIBBLE_W-1] ^ b_q[idx][NIBBLE_W-1] ^ slice_s[NIBBLE_W-1];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            idx   <= '0;
            carry <= 1'b0;
            c_q   <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        a_q <= A_in;
                        idx <= '0;
`ifdef SUB_MODE_EN
                        b_q   <= sub_in ? ~B_in : B_in;
                        carry <= sub_in | C_in;
`else
                        b_q   <= B_in;
                        carry <= C_in;
`endif
                    end
                end
                RUN: begin
                    s_q[idx] <= slice_s;
                    carry    <= slice_c;
                    if (last) begin
                        idx   <= '0;
                        c_q   <= slice_c;
                        ovf_q <= msb_cin ^ slice_c;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        busy_out  = 1'b0;
        done_out  = 1'b0;
        case (state)
            IDLE: if (start_in) state_nxt = RUN;
            RUN: begin
                busy_out = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done_out  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign S_out   = s_q;
    assign C_out   = c_q;
    assign ovf_out = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed-vector bench for nibble_serial_add_ctrl (NIBBLES=4); subtract vectors run when SUB_MODE_EN is defined.
module tb_nibble_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        c_in;
`ifdef SUB_MODE_EN
    logic        sub_in;
`endif
    logic        busy;
    logic        done;
    logic [15:0] s_out;
    logic        c_out;
    logic        ovf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
        .clk_in   (clk),
        .rst_in   (rst),
        .start_in (start),
`ifdef SUB_MODE_EN
        .sub_in   (sub_in),
`endif
        .A_in     (a_in),
        .B_in     (b_in),
        .C_in     (c_in),
        .busy_out (busy),
        .done_out (done),
        .S_out    (s_out),
        .C_out    (c_out),
        .ovf_out  (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // One full operation; inputs are scrambled after capture to prove they are latched.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic sub, input logic [15:0] es,
                          input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        c_in  = c;
`ifdef SUB_MODE_EN
        sub_in = sub;
`else
        if (sub) $display("note: sub vector %s run as add", tag);
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = ~a;
        b_in  = ~b;
        c_in  = ~c;
        chk({tag, "_busy"}, busy, 1);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_s"}, s_out, es);
        chk({tag, "_c"}, c_out, ec);
        chk({tag, "_ovf"}, ovf, eo);
        @(posedge clk);
        #1;
        chk({tag, "_done_1cyc"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int ndone;
        logic [15:0] s_seen;
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        c_in  = 1'b0;
`ifdef SUB_MODE_EN
        sub_in = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_s", s_out, 0);
        chk("rst_c", c_out, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add1234", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("carry",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

        // start held high through the whole operation
        @(negedge clk);
        a_in  = 16'h0007;
        b_in  = 16'h0003;
        c_in  = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        a_in   = 16'hFFFF;
        ndone  = 0;
        s_seen = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                s_seen = s_out;
            end
        end
        chk("hold_ndone", ndone, 1);
        chk("hold_s", s_seen, 16'h000B);
        chk("hold_idle_gap", busy, 0);
        @(posedge clk);
        #1;
        chk("hold_restart", busy, 1);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone = 1;
                break;
            end
        end
        chk("second_done", ndone, 1);
        chk("second_s", s_out, 16'h0003);
        chk("second_c", c_out, 1);
        @(posedge clk);

        // reset during the second RUN cycle
        @(negedge clk);
        a_in  = 16'h1111;
        b_in  = 16'h2222;
        c_in  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_s", s_out, 0);
        chk("abort_done", done, 0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run_op("post_rst", 16'h0004, 16'h0003, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

`ifdef SUB_MODE_EN
        run_op("sub5_7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub7_5", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
